// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   state_e      : 3-bit controller state encoding
//   ctl_t        : bundle of the combinational pipeline control outputs
//   OP_HLT       : opcode of the halt instruction as seen by the decoder
//   DRAIN_CYCLES_DEF : default cycles from HLT in ID until it retires from WB
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_IMISS  = 3'd1,
    ST_DMISS  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
    logic pc_redirect;
    logic tgt_latch_en;
    logic pc_use_latched;
  } ctl_t;

  localparam logic [3:0]  OP_HLT           = 4'b1111;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk     : clock
//   clear_i : synchronous clear, dominates inc_i
//   inc_i   : count up by one this cycle
//   count_o : current count, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller for a 5-stage in-order core: resolves load-use stalls,
// taken branches, I/D-cache fills and the HLT drain into per-stage write
// enables, bubble flushes and PC mux selects.
//   clk, rst_n        : clock, synchronous active-low reset
//   stall_ld          : load-to-use hazard between ID and EX
//   br_taken          : branch/jump resolved taken in ID
//   halt_id           : HLT valid in ID
//   imiss, dmiss      : I-/D-cache fill in progress (level)
//   *_en              : pipeline register write enables
//   *_flush           : load a bubble into that pipeline register
//   pc_redirect       : PC takes the live branch target
//   tgt_latch_en      : capture the branch target into the hold register
//   pc_use_latched    : PC takes the held branch target
//   halted            : registered, processor halted until reset
//   stall_count       : registered, saturating count of cycles with pc_en=0
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_ld,
  input  logic             br_taken,
  input  logic             halt_id,
  input  logic             imiss,
  input  logic             dmiss,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             pc_redirect,
  output logic             tgt_latch_en,
  output logic             pc_use_latched,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_e        state_q, state_d, eff_state;
  logic          pend_q, pend_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          halted_q, halted_d;
  ctl_t          ctl;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    ctl          = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                     memwb_en: 1'b1, default: 1'b0};
    state_d      = state_q;
    pend_d       = pend_q;
    drain_d      = drain_q;
    halted_d     = halted_q;
    // The first cycle after a D-miss clears is decoded exactly like RUN, so
    // an I-miss still pending at that point is caught without a free fetch.
    eff_state    = ((state_q == ST_DMISS) && !dmiss) ? ST_RUN : state_q;

    if (rst_n) begin
      case (eff_state)
        ST_RUN: begin
          if (dmiss) begin
            {ctl.pc_en, ctl.ifid_en, ctl.idex_en, ctl.exmem_en} = 4'b0000;
            ctl.memwb_flush = 1'b1;
            state_d         = ST_DMISS;
          end else if (halt_id) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_flush = 1'b1;
            drain_d        = DW'(DRAIN_CYCLES);
            state_d        = ST_DRAIN;
          end else if (stall_ld) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_en    = 1'b0;
            ctl.idex_flush = 1'b1;
          end else if (br_taken && imiss) begin
            ctl.pc_en        = 1'b0;
            ctl.ifid_flush   = 1'b1;
            ctl.tgt_latch_en = 1'b1;
            pend_d           = 1'b1;
            state_d          = ST_IMISS;
          end else if (br_taken) begin
            ctl.pc_redirect = 1'b1;
            ctl.ifid_flush  = 1'b1;
          end else if (imiss) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_flush = 1'b1;
            state_d        = ST_IMISS;
          end else begin
            // A held target left over from an I-miss that finished while a
            // D-miss blocked the front end is consumed on the next free fetch.
            ctl.pc_use_latched = pend_q;
            pend_d             = 1'b0;
          end
        end
        ST_IMISS: begin
          if (dmiss) begin
            {ctl.pc_en, ctl.ifid_en, ctl.idex_en, ctl.exmem_en} = 4'b0000;
            ctl.memwb_flush = 1'b1;
            state_d         = ST_DMISS;
          end else if (stall_ld) begin
            // Exit waits for the hazard to clear so the held target is not
            // dropped on a cycle where the PC cannot load.
            ctl.pc_en      = 1'b0;
            ctl.ifid_en    = 1'b0;
            ctl.idex_flush = 1'b1;
          end else if (imiss) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_flush = 1'b1;
          end else begin
            ctl.pc_use_latched = pend_q;
            pend_d             = 1'b0;
            state_d            = ST_RUN;
          end
        end
        ST_DMISS: begin
          {ctl.pc_en, ctl.ifid_en, ctl.idex_en, ctl.exmem_en} = 4'b0000;
          ctl.memwb_flush = 1'b1;
        end
        ST_DRAIN: begin
          if (dmiss) begin
            {ctl.pc_en, ctl.ifid_en, ctl.idex_en, ctl.exmem_en} = 4'b0000;
            ctl.memwb_flush = 1'b1;
            state_d         = ST_DMISS;
          end else begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_flush = 1'b1;
            if (drain_q <= DW'(1)) begin
              drain_d  = '0;
              halted_d = 1'b1;
              state_d  = ST_HALTED;
            end else begin
              drain_d = drain_q - DW'(1);
            end
          end
        end
        ST_HALTED: begin
          {ctl.pc_en, ctl.ifid_en, ctl.idex_en, ctl.exmem_en, ctl.memwb_en} = 5'b00000;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pend_q   <= 1'b0;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_i (!rst_n),
    .inc_i   (!ctl.pc_en),
    .count_o (stall_count)
  );

  assign pc_en          = ctl.pc_en;
  assign ifid_en        = ctl.ifid_en;
  assign idex_en        = ctl.idex_en;
  assign exmem_en       = ctl.exmem_en;
  assign memwb_en       = ctl.memwb_en;
  assign ifid_flush     = ctl.ifid_flush;
  assign idex_flush     = ctl.idex_flush;
  assign memwb_flush    = ctl.memwb_flush;
  assign pc_redirect    = ctl.pc_redirect;
  assign tgt_latch_en   = ctl.tgt_latch_en;
  assign pc_use_latched = ctl.pc_use_latched;
  assign halted         = halted_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning the cycles from HLT in ID until WB retires.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-003 SHALL have clk  in  1  system clock; one clock domain; all state updates on rising edge.
REQ-004 SHALL have rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have stall_ld  in  1  load-to-use stall request from the hazard unit (ID vs EX).
REQ-006 SHALL have br_taken  in  1  branch/jump resolved taken in ID.
REQ-007 SHALL have halt_id  in  1  HLT (opcode 4'b1111) valid in ID.
REQ-008 SHALL have imiss  in  1  I-cache fill in progress; level signal.
REQ-009 SHALL have dmiss  in  1  D-cache fill in progress; level signal.
REQ-010 SHALL have pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register write enables.
REQ-011 SHALL have ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (NOP, RF write off) into that register.
REQ-012 SHALL have pc_redirect  out  1  PC mux selects the live branch target.
REQ-013 SHALL have tgt_latch_en  out  1  datapath captures the branch target into its hold register.
REQ-014 SHALL have pc_use_latched  out  1  PC mux selects the held target.
REQ-015 SHALL have halted  out  1  registered; processor halted.
REQ-016 SHALL have stall_count  out  CNT_W  registered count of cycles with pc_en=0.

Function
REQ-017 SHALL implement states RUN, IMISS, DMISS, DRAIN, HALTED; control outputs decode combinationally from state and inputs.
REQ-018 SHALL default to all enables=1, all flushes/redirects=0 unless a rule below overrides.
REQ-019 SHALL, in RUN/IMISS/DRAIN with dmiss=1 (highest priority): drive pc/ifid/idex/exmem_en=0 and memwb_flush=1, then go to DMISS.
REQ-020 SHALL hold DMISS with the same outputs while dmiss=1 and return to RUN on the first cycle dmiss=0.
REQ-021 SHALL, in RUN with halt_id=1: drive pc_en=0 and ifid_flush=1, load the drain counter with DRAIN_CYCLES, and go to DRAIN.
REQ-022 SHALL, in RUN/IMISS with stall_ld=1: drive pc_en=0, ifid_en=0 and idex_flush=1; ifid_flush is suppressed.
REQ-023 SHALL, in RUN with br_taken=1, imiss=0 and stall_ld=0: drive pc_redirect=1 and ifid_flush=1.
REQ-024 SHALL, in RUN with br_taken=1 and imiss=1: drive pc_en=0, ifid_flush=1 and tgt_latch_en=1, set redirect_pend, and go to IMISS.
REQ-025 SHALL, in RUN with imiss=1 and no higher-priority event: drive pc_en=0 and ifid_flush=1, and go to IMISS.
REQ-026 SHALL, in IMISS: drive pc_en=0 and ifid_flush=1 while imiss=1; on imiss=0, drive pc_en=1 and pc_use_latched=redirect_pend, clear redirect_pend, and go to RUN.
REQ-027 SHALL, in DRAIN: drive pc_en=0 and ifid_flush=1, decrement the counter each cycle, and go to HALTED when the counter reaches 0 after DRAIN_CYCLES cycles.
REQ-028 SHALL, in HALTED: drive all enables=0 and halted=1; the only exit is reset.
REQ-029 SHALL increment stall_count every cycle pc_en=0 (including HALTED), saturating at all-ones with no wrap.
REQ-030 SHALL keep redirect_pend across a DMISS interruption of IMISS; the RUN→IMISS re-entry then honours it.

Reset
REQ-031 SHALL, on rst_n=0 at a clock edge: state=RUN, redirect_pend=0, drain counter=0, halted=0, stall_count=0; reset mid-miss or mid-drain abandons the operation.
REQ-032 SHALL drive outputs during reset as RUN with all inputs ignored: enables=1, flushes=0.

Structure
REQ-033 SHALL place the state encoding (3-bit), the HLT opcode constant and the DRAIN_CYCLES default in the shared package pipe_ctrl_pkg.
REQ-034 SHALL implement stall_count in one sub-module, sat_counter (parameter width, inc, clear).

Verification
REQ-035 SHALL cover: stall_ld=1 for 1 cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1 that cycle, stall_count=1.
REQ-036 SHALL cover: dmiss high 5 cycles while imiss=1 -> pc/ifid/idex/exmem_en=0 and memwb_flush=1 for 5 cycles; next cycle state IMISS.
REQ-037 SHALL cover: br_taken and imiss both high, imiss held 4 cycles -> tgt_latch_en=1 once, pc_en=0 for 4 cycles, then pc_use_latched=1 with pc_en=1 for exactly 1 cycle.
REQ-038 SHALL cover: halt_id=1 -> pc_en=0 for 4 cycles (1+DRAIN_CYCLES), halted=1 on the 5th, held until rst_n=0.
REQ-039 SHALL cover: CNT_W=4 with 20 stall cycles -> stall_count=15, no wrap.
REQ-040 SHALL cover: rst_n=0 mid-DRAIN -> next cycle halted=0, stall_count=0, all enables=1.
